// File: rtl/sa_output_collector_if.sv
// Array-output and tile-writeback signal bundle for the systolic array output collector.
// The slave modport is the collector; the master modport is the array/writeback side.
interface sa_output_collector_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16
);
  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

  logic              out_en;
  logic [RowW-1:0]   row_out;
  logic [DW*N-1:0]   array_output;
  logic              col_has_space;
  logic              tile_valid;
  logic              tile_ready;
  logic [DW*N-1:0]   tile_row_data;
  logic [RowW-1:0]   tile_row_idx;
  logic              tile_last;
  logic              order_err;
  logic              overflow_err;

  modport slave (
    input  out_en, row_out, array_output, tile_ready,
    output col_has_space, tile_valid, tile_row_data, tile_row_idx, tile_last,
           order_err, overflow_err
  );

  modport master (
    output out_en, row_out, array_output, tile_ready,
    input  col_has_space, tile_valid, tile_row_data, tile_row_idx, tile_last,
           order_err, overflow_err
  );
endinterface

// File: rtl/sa_output_collector.sv
// Collects drained systolic-array rows into a two-bank ping-pong tile buffer and
// streams each completed tile out one row per valid/ready beat.
module sa_output_collector #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16
) (
  input logic                     clk,
  input logic                     rst,
  sa_output_collector_if.slave    bus
);
  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(N - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_st_e;

  logic [DW*N-1:0] mem_q [2][N];
  bank_st_e        state_q [2];
  logic            wr_bank_q;
  logic            rd_bank_q;
  logic [RowW-1:0] wr_row_q;
  logic [RowW-1:0] rd_row_q;
  logic            order_err_q;
  logic            overflow_err_q;

  logic wr_full;
  logic tile_valid;
  logic rd_fire;

  assign wr_full    = (state_q[wr_bank_q] == StFull);
  assign tile_valid = (state_q[rd_bank_q] == StFull);
  assign rd_fire    = tile_valid && bus.tile_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= StEmpty;
        for (int r = 0; r < int'(N); r++) begin
          mem_q[b][r] <= '0;
        end
      end
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_row_q       <= '0;
      rd_row_q       <= '0;
      order_err_q    <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      // Write and read never touch the same bank in one cycle: a write needs a
      // non-FULL bank, a read beat needs a FULL one.
      if (bus.out_en) begin
        if (wr_full) begin
          overflow_err_q <= 1'b1;
        end else begin
          mem_q[wr_bank_q][bus.row_out] <= bus.array_output;
          if (bus.row_out != wr_row_q) begin
            order_err_q <= 1'b1;
          end
          if (wr_row_q == LastRow) begin
            state_q[wr_bank_q] <= StFull;
            wr_bank_q          <= ~wr_bank_q;
            wr_row_q           <= '0;
          end else begin
            state_q[wr_bank_q] <= StFilling;
            wr_row_q           <= wr_row_q + 1'b1;
          end
        end
      end
      if (rd_fire) begin
        if (rd_row_q == LastRow) begin
          state_q[rd_bank_q] <= StEmpty;
          rd_bank_q          <= ~rd_bank_q;
          rd_row_q           <= '0;
        end else begin
          rd_row_q <= rd_row_q + 1'b1;
        end
      end
    end
  end

  assign bus.col_has_space = ~wr_full;
  assign bus.tile_valid    = tile_valid;
  assign bus.tile_row_data = mem_q[rd_bank_q][rd_row_q];
  assign bus.tile_row_idx  = rd_row_q;
  assign bus.tile_last     = tile_valid && (rd_row_q == LastRow);
  assign bus.order_err     = order_err_q;
  assign bus.overflow_err  = overflow_err_q;

endmodule

// File: tb/tb_sa_output_collector.sv
// Directed self-checking bench for sa_output_collector (N=4, DW=16).
module tb_sa_output_collector;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sa_output_collector_if #(.N(N), .DW(DW)) bus ();

  sa_output_collector #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int t, input int r);
    logic [15:0] b;
    b = 16'(16'hA000 + t * 256 + r * 16);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.out_en       = 1'b0;
    bus.row_out      = '0;
    bus.array_output = '0;
    bus.tile_ready   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push(input int r, input logic [63:0] d);
    bus.out_en       = 1'b1;
    bus.row_out      = 2'(r);
    bus.array_output = d;
    tick();
    bus.out_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_space"}, 64'(bus.col_has_space), 64'd1);
    check({tag, "_valid"}, 64'(bus.tile_valid), 64'd0);
    check({tag, "_last"}, 64'(bus.tile_last), 64'd0);
    check({tag, "_idx"}, 64'(bus.tile_row_idx), 64'd0);
    check({tag, "_data"}, bus.tile_row_data, 64'd0);
    check({tag, "_oerr"}, 64'(bus.order_err), 64'd0);
    check({tag, "_ovf"}, 64'(bus.overflow_err), 64'd0);
  endtask

  // Checks the beat on the bus, then lets it handshake (tile_ready must be 1).
  task automatic expect_beat(input string tag, input int t, input int r);
    check({tag, "_valid"}, 64'(bus.tile_valid), 64'd1);
    check({tag, "_data"}, bus.tile_row_data, mk(t, r));
    check({tag, "_idx"}, 64'(bus.tile_row_idx), 64'(r));
    check({tag, "_last"}, 64'(bus.tile_last), 64'(r == 3));
    tick();
  endtask

  initial begin
    int beat;
    int cyc;
    logic [7:0] pat;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;

    // 1: single tile, latency and beat order
    do_reset();
    check_idle("t1_reset");
    bus.tile_ready = 1'b1;
    push(0, mk(0, 0));
    push(1, mk(0, 1));
    push(2, mk(0, 2));
    check("t1_not_yet_valid", 64'(bus.tile_valid), 64'd0);
    push(3, mk(0, 3));
    for (int r = 0; r < 4; r++) expect_beat("t1_beat", 0, r);
    check("t1_drained", 64'(bus.tile_valid), 64'd0);
    check("t1_oerr", 64'(bus.order_err), 64'd0);
    check("t1_ovf", 64'(bus.overflow_err), 64'd0);

    // 2: both banks full, overflow dropped, then drain both tiles
    do_reset();
    for (int r = 0; r < 4; r++) push(r, mk(0, r));
    check("t2_space_one_full", 64'(bus.col_has_space), 64'd1);
    for (int r = 0; r < 4; r++) push(r, mk(1, r));
    check("t2_space_both_full", 64'(bus.col_has_space), 64'd0);
    check("t2_ovf_before", 64'(bus.overflow_err), 64'd0);
    push(0, mk(9, 0));
    check("t2_ovf_set", 64'(bus.overflow_err), 64'd1);
    check("t2_oerr", 64'(bus.order_err), 64'd0);
    bus.tile_ready = 1'b1;
    for (int r = 0; r < 4; r++) expect_beat("t2_tile0", 0, r);
    check("t2_space_freed", 64'(bus.col_has_space), 64'd1);
    for (int r = 0; r < 4; r++) expect_beat("t2_tile1", 1, r);
    check("t2_drained", 64'(bus.tile_valid), 64'd0);
    check("t2_ovf_sticky", 64'(bus.overflow_err), 64'd1);

    // 3: out-of-order rows are stored by row_out
    do_reset();
    push(0, mk(2, 0));
    check("t3_oerr_first", 64'(bus.order_err), 64'd0);
    push(2, mk(2, 2));
    check("t3_oerr_set", 64'(bus.order_err), 64'd1);
    push(1, mk(2, 1));
    check("t3_not_full", 64'(bus.tile_valid), 64'd0);
    push(3, mk(2, 3));
    bus.tile_ready = 1'b1;
    for (int r = 0; r < 4; r++) expect_beat("t3_beat", 2, r);
    check("t3_drained", 64'(bus.tile_valid), 64'd0);

    // 4: stalled drain holds data, no beat lost or duplicated
    do_reset();
    for (int r = 0; r < 4; r++) push(r, mk(3, r));
    pat  = 8'b1011_1001;  // ready pattern read LSB first: 1,0,0,1,1,1,0,1
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 16) begin
      bus.tile_ready = pat[cyc % 8];
      check("t4_valid", 64'(bus.tile_valid), 64'd1);
      check("t4_data", bus.tile_row_data, mk(3, beat));
      check("t4_idx", 64'(bus.tile_row_idx), 64'(beat));
      if (bus.tile_ready) beat++;
      tick();
      cyc++;
    end
    check("t4_beats_done", 64'(beat), 64'd4);
    check("t4_drained", 64'(bus.tile_valid), 64'd0);

    // 5: continuous streaming, one row in and one out per cycle
    do_reset();
    bus.tile_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        bus.out_en       = 1'b1;
        bus.row_out      = 2'(c % 4);
        bus.array_output = mk(4 + c / 4, c % 4);
      end else begin
        bus.out_en = 1'b0;
      end
      tick();
      check("t5_space", 64'(bus.col_has_space), 64'd1);
      if (c >= 3 && c <= 18) begin
        check("t5_valid", 64'(bus.tile_valid), 64'd1);
        check("t5_data", bus.tile_row_data, mk(4 + (c - 3) / 4, (c - 3) % 4));
        check("t5_last", 64'(bus.tile_last), 64'((c - 3) % 4 == 3));
      end
    end
    bus.out_en = 1'b0;
    check("t5_drained", 64'(bus.tile_valid), 64'd0);
    check("t5_ovf", 64'(bus.overflow_err), 64'd0);

    // 6: mid-tile reset discards the partial tile
    do_reset();
    push(0, mk(5, 0));
    push(3, mk(5, 3));
    check("t6_oerr_pre", 64'(bus.order_err), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("t6_async_reset");
    tick();
    rst = 1'b0;
    tick();
    bus.tile_ready = 1'b1;
    for (int r = 0; r < 4; r++) push(r, mk(6, r));
    for (int r = 0; r < 4; r++) expect_beat("t6_beat", 6, r);
    check("t6_drained", 64'(bus.tile_valid), 64'd0);
    check("t6_oerr", 64'(bus.order_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
